// File: rtl/control_unit_mc_if.sv
// Shared types and the decoder/datapath <-> control unit bus.
//
// k_and_s_pkg
//   decoded_instruction_type : instruction class produced by the decoder.
//
// control_unit_mc_if
//   decoded_instruction              decoder -> control
//   zero_op, neg_op                  datapath flags -> control
//   unsigned_overflow                datapath flag -> control
//   signed_overflow                  datapath flag -> control
//   branch, pc_enable, ir_enable     control -> datapath
//   write_reg_enable, addr_sel       control -> datapath
//   c_sel, operation[1:0]            control -> datapath (ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND)
//   flags_reg_enable                 control -> datapath
//   ram_write_enable                 control -> RAM
//   modport master : control unit side; modport slave : datapath/decoder side.

package k_and_s_pkg;
    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_LOAD   = 4'd1,
        I_STORE  = 4'd2,
        I_MOVE   = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNZERO = 4'd10,
        I_BNEG   = 4'd11,
        I_BNNEG  = 4'd12,
        I_BOV    = 4'd13,
        I_BNOV   = 4'd14,
        I_HALT   = 4'd15
    } decoded_instruction_type;
endpackage

interface control_unit_mc_if;
    import k_and_s_pkg::*;

    decoded_instruction_type decoded_instruction;
    logic                    zero_op;
    logic                    neg_op;
    logic                    unsigned_overflow;
    logic                    signed_overflow;
    logic                    branch;
    logic                    pc_enable;
    logic                    ir_enable;
    logic                    write_reg_enable;
    logic                    addr_sel;
    logic                    c_sel;
    logic [1:0]              operation;
    logic                    flags_reg_enable;
    logic                    ram_write_enable;

    modport master (
        input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
        output branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel, operation,
               flags_reg_enable, ram_write_enable
    );

    modport slave (
        output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
        input  branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel, operation,
               flags_reg_enable, ram_write_enable
    );
endinterface

// File: rtl/control_unit_mc.sv
// Multicycle K&S control FSM with configurable RAM read latency, selectable overflow flag
// for BOV/BNOV, single-step debug mode and a retired-instruction counter.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   bus          master modport: decoded instruction + flags in, datapath/RAM controls out
//   step_mode    in   1: one instruction per step_req token
//   step_req     in   step token request, level sampled each cycle
//   halt         out  program ended (terminal until reset)
//   retired_cnt  out  completed instruction count, wraps modulo 2^CNT_W
//
// All outputs are decoded from the state (plus instruction/flags in DECODE and ALU_WB).

module control_unit_mc
    import k_and_s_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1,
    parameter bit          OV_SIGNED   = 1'b0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    control_unit_mc_if.master  bus,
    input  logic               step_mode,
    input  logic               step_req,
    output logic               halt,
    output logic [CNT_W-1:0]   retired_cnt
);

    typedef enum logic [3:0] {
        StFetch,
        StLatchIr,
        StDecode,
        StLoadWait,
        StLoadWb,
        StStoreWr,
        StAluWb,
        StBranchTake,
        StHalted
    } state_e;

    localparam int unsigned WaitW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    // Last wait_cnt value of FETCH and of LOAD_WAIT (FETCH lasts L cycles, LOAD_WAIT L-1).
    localparam logic [WaitW-1:0] FetchLast = WaitW'(MEM_LATENCY - 1);
    localparam logic [WaitW-1:0] LoadLast  = WaitW'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic               token_q, token_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fetch_exit;
    logic               retire;
    logic               cond_taken;
    logic [1:0]         alu_op;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            wait_q  <= '0;
            token_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            token_q <= token_d;
            cnt_q   <= cnt_d;
        end
    end

    // Conditional branch evaluation and ALU opcode for the current instruction
    always_comb begin
        cond_taken = 1'b0;
        alu_op     = 2'b00;
        case (bus.decoded_instruction)
            I_BZERO:  cond_taken = bus.zero_op;
            I_BNZERO: cond_taken = ~bus.zero_op;
            I_BNEG:   cond_taken = bus.neg_op;
            I_BNNEG:  cond_taken = ~bus.neg_op;
            I_BOV:    cond_taken = OV_SIGNED ? bus.signed_overflow : bus.unsigned_overflow;
            I_BNOV:   cond_taken = OV_SIGNED ? ~bus.signed_overflow : ~bus.unsigned_overflow;
            I_ADD:    alu_op = 2'b01;
            I_SUB:    alu_op = 2'b10;
            I_AND:    alu_op = 2'b11;
            default:  ;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        fetch_exit = 1'b0;
        retire     = 1'b0;
        case (state_q)
            StFetch: begin
                if (step_mode && !token_q) begin
                    // waiting for a step token; latency count frozen
                end else if (wait_q < FetchLast) begin
                    wait_d = wait_q + 1'b1;
                end else begin
                    state_d    = StLatchIr;
                    wait_d     = '0;
                    fetch_exit = 1'b1;
                end
            end
            StLatchIr: state_d = StDecode;
            StDecode: begin
                case (bus.decoded_instruction)
                    I_HALT:   state_d = StHalted;
                    I_BRANCH: state_d = StBranchTake;
                    I_MOVE, I_ADD, I_SUB, I_AND, I_OR: state_d = StAluWb;
                    I_LOAD:   state_d = (MEM_LATENCY > 1) ? StLoadWait : StLoadWb;
                    I_STORE:  state_d = StStoreWr;
                    default:  state_d = StFetch;
                endcase
                retire = (state_d == StFetch) || (state_d == StHalted);
            end
            StLoadWait: begin
                if (wait_q < LoadLast) begin
                    wait_d = wait_q + 1'b1;
                end else begin
                    wait_d  = '0;
                    state_d = StLoadWb;
                end
            end
            StLoadWb, StStoreWr, StAluWb, StBranchTake: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StHalted: state_d = StHalted;
            default:  state_d = StFetch;
        endcase
    end

    // A request in the exit cycle of FETCH keeps the token for the next instruction.
    always_comb begin
        token_d = token_q;
        if (step_req) begin
            token_d = 1'b1;
        end else if (fetch_exit) begin
            token_d = 1'b0;
        end
        cnt_d = retire ? cnt_q + 1'b1 : cnt_q;
    end

    // Output decode
    always_comb begin
        bus.branch           = 1'b0;
        bus.pc_enable        = 1'b0;
        bus.ir_enable        = 1'b0;
        bus.write_reg_enable = 1'b0;
        bus.addr_sel         = 1'b0;
        bus.c_sel            = 1'b0;
        bus.operation        = 2'b00;
        bus.flags_reg_enable = 1'b0;
        bus.ram_write_enable = 1'b0;
        halt                 = 1'b0;
        case (state_q)
            StLatchIr: begin
                bus.ir_enable = 1'b1;
                bus.pc_enable = 1'b1;
            end
            StDecode: begin
                case (bus.decoded_instruction)
                    I_ADD, I_SUB, I_AND, I_OR: begin
                        bus.c_sel     = 1'b1;
                        bus.operation = alu_op;
                    end
                    I_LOAD, I_STORE: bus.addr_sel = 1'b1;
                    I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
                        bus.branch    = cond_taken;
                        bus.pc_enable = cond_taken;
                    end
                    default: ;
                endcase
            end
            StLoadWait: bus.addr_sel = 1'b1;
            StLoadWb: begin
                bus.addr_sel         = 1'b1;
                bus.write_reg_enable = 1'b1;
            end
            StStoreWr: begin
                bus.addr_sel         = 1'b1;
                bus.ram_write_enable = 1'b1;
            end
            StAluWb: begin
                bus.write_reg_enable = 1'b1;
                bus.c_sel            = 1'b1;
                bus.flags_reg_enable = 1'b1;
                bus.operation        = alu_op;
            end
            StBranchTake: begin
                bus.branch    = 1'b1;
                bus.pc_enable = 1'b1;
            end
            StHalted: halt = 1'b1;
            default: ;
        endcase
    end

    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_control_unit_mc.sv
// Three control units with different parameters, each driven by an instruction-level
// model that predicts the per-cycle control vector and retired count.

module tb_control_unit_mc;
    import k_and_s_pkg::*;

    // Control vector layout: {branch, pc, ir, wr, addr_sel, c_sel, op[1:0], flags, ram_we, halt}
    localparam logic [10:0] V_BR = 11'h400;
    localparam logic [10:0] V_PC = 11'h200;
    localparam logic [10:0] V_IR = 11'h100;
    localparam logic [10:0] V_WR = 11'h080;
    localparam logic [10:0] V_AS = 11'h040;
    localparam logic [10:0] V_CS = 11'h020;
    localparam logic [10:0] V_FL = 11'h004;
    localparam logic [10:0] V_RW = 11'h002;
    localparam logic [10:0] V_H  = 11'h001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    decoded_instruction_type instr_s [3];
    logic rst_s [3];
    logic zero_s [3];
    logic neg_s [3];
    logic uo_s [3];
    logic so_s [3];
    logic smode_s [3];
    logic sreq_s [3];

    logic [10:0] out_v [3];
    logic [15:0] cnt_v [3];
    logic halt0, halt1, halt2;
    logic [15:0] cnt0, cnt1;
    logic [1:0] cnt2;

    logic [10:0] exp_v [3];
    logic [15:0] exp_cnt [3];
    bit exp_on [3];
    int mcnt [3];

    bit lit_on;
    int lit_k;
    logic [10:0] lit_v;
    logic [15:0] lit_cnt_e;

    int checks = 0;
    int errors = 0;

    control_unit_mc_if bus0 ();
    control_unit_mc_if bus1 ();
    control_unit_mc_if bus2 ();

    assign bus0.decoded_instruction = instr_s[0];
    assign bus0.zero_op = zero_s[0];
    assign bus0.neg_op = neg_s[0];
    assign bus0.unsigned_overflow = uo_s[0];
    assign bus0.signed_overflow = so_s[0];
    assign bus1.decoded_instruction = instr_s[1];
    assign bus1.zero_op = zero_s[1];
    assign bus1.neg_op = neg_s[1];
    assign bus1.unsigned_overflow = uo_s[1];
    assign bus1.signed_overflow = so_s[1];
    assign bus2.decoded_instruction = instr_s[2];
    assign bus2.zero_op = zero_s[2];
    assign bus2.neg_op = neg_s[2];
    assign bus2.unsigned_overflow = uo_s[2];
    assign bus2.signed_overflow = so_s[2];

    assign out_v[0] = {bus0.branch, bus0.pc_enable, bus0.ir_enable, bus0.write_reg_enable,
                       bus0.addr_sel, bus0.c_sel, bus0.operation, bus0.flags_reg_enable,
                       bus0.ram_write_enable, halt0};
    assign out_v[1] = {bus1.branch, bus1.pc_enable, bus1.ir_enable, bus1.write_reg_enable,
                       bus1.addr_sel, bus1.c_sel, bus1.operation, bus1.flags_reg_enable,
                       bus1.ram_write_enable, halt1};
    assign out_v[2] = {bus2.branch, bus2.pc_enable, bus2.ir_enable, bus2.write_reg_enable,
                       bus2.addr_sel, bus2.c_sel, bus2.operation, bus2.flags_reg_enable,
                       bus2.ram_write_enable, halt2};
    assign cnt_v[0] = cnt0;
    assign cnt_v[1] = cnt1;
    assign cnt_v[2] = {14'd0, cnt2};

    control_unit_mc #(.MEM_LATENCY(1), .OV_SIGNED(1'b0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst_s[0]), .bus(bus0), .step_mode(smode_s[0]), .step_req(sreq_s[0]),
        .halt(halt0), .retired_cnt(cnt0)
    );
    control_unit_mc #(.MEM_LATENCY(3), .OV_SIGNED(1'b1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst_s[1]), .bus(bus1), .step_mode(smode_s[1]), .step_req(sreq_s[1]),
        .halt(halt1), .retired_cnt(cnt1)
    );
    control_unit_mc #(.MEM_LATENCY(2), .OV_SIGNED(1'b0), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst_s[2]), .bus(bus2), .step_mode(smode_s[2]), .step_req(sreq_s[2]),
        .halt(halt2), .retired_cnt(cnt2)
    );

    function automatic int lat_of(input int k);
        case (k)
            0: return 1;
            1: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic bit ovs_of(input int k);
        return k == 1;
    endfunction

    function automatic int cw_of(input int k);
        return (k == 2) ? 2 : 16;
    endfunction

    function automatic logic [10:0] opv(input decoded_instruction_type ins);
        case (ins)
            I_ADD: return 11'd1 << 3;
            I_SUB: return 11'd2 << 3;
            I_AND: return 11'd3 << 3;
            default: return 11'd0;
        endcase
    endfunction

    // Compare process: every meaningful cycle, plus hand-computed literal expectations.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (exp_on[k]) begin
                    checks++;
                    if (out_v[k] !== exp_v[k] || cnt_v[k] !== exp_cnt[k]) begin
                        errors++;
                        $display("FAIL cycle_check dut%0d t=%0t outputs=%b retired=%0d expected outputs=%b retired=%0d",
                                 k, $time, out_v[k], cnt_v[k], exp_v[k], exp_cnt[k]);
                    end
                end
            end
            if (lit_on) begin
                checks++;
                if (out_v[lit_k] !== lit_v || cnt_v[lit_k] !== lit_cnt_e) begin
                    errors++;
                    $display("FAIL literal_check dut%0d t=%0t outputs=%b retired=%0d expected outputs=%b retired=%0d",
                             lit_k, $time, out_v[lit_k], cnt_v[lit_k], lit_v, lit_cnt_e);
                end
            end
        end
    end

    task automatic cyc(input int k, input logic [10:0] v);
        exp_v[k] = v;
        exp_cnt[k] = 16'(mcnt[k]);
        exp_on[k] = 1'b1;
        @(posedge clk);
        #1;
        lit_on = 1'b0;
    endtask

    task automatic retire_one(input int k);
        mcnt[k] = (mcnt[k] + 1) % (1 << cw_of(k));
    endtask

    task automatic set_lit(input int k, input logic [10:0] v, input int c);
        lit_on = 1'b1;
        lit_k = k;
        lit_v = v;
        lit_cnt_e = 16'(c);
    endtask

    task automatic do_reset(input int k);
        rst_s[k] = 1'b1;
        smode_s[k] = 1'b0;
        sreq_s[k] = 1'b0;
        mcnt[k] = 0;
        cyc(k, '0);
        cyc(k, '0);
        rst_s[k] = 1'b0;
    endtask

    // One instruction: hold >= 0 means step mode with that many idle FETCH cycles before the
    // step_req pulse. HALT stops after DECODE; the caller checks the halted cycles.
    task automatic exec(input int k, input decoded_instruction_type ins, input logic z,
                        input logic n, input logic uo, input logic so, input int hold,
                        input bit abort_store);
        bit take;
        logic ov;
        instr_s[k] = ins;
        zero_s[k] = z;
        neg_s[k] = n;
        uo_s[k] = uo;
        so_s[k] = so;
        if (hold >= 0) begin
            for (int i = 0; i < hold; i++) cyc(k, '0);
            sreq_s[k] = 1'b1;
            cyc(k, '0);
            sreq_s[k] = 1'b0;
        end
        for (int i = 0; i < lat_of(k); i++) cyc(k, '0);
        cyc(k, V_IR | V_PC);
        ov = ovs_of(k) ? so : uo;
        case (ins)
            I_HALT: begin
                cyc(k, '0);
                retire_one(k);
            end
            I_BRANCH: begin
                cyc(k, '0);
                cyc(k, V_BR | V_PC);
                retire_one(k);
            end
            I_MOVE, I_ADD, I_SUB, I_AND, I_OR: begin
                cyc(k, (ins == I_MOVE) ? 11'd0 : (V_CS | opv(ins)));
                cyc(k, V_WR | V_CS | V_FL | opv(ins));
                retire_one(k);
            end
            I_LOAD: begin
                for (int i = 0; i < lat_of(k); i++) cyc(k, V_AS);
                cyc(k, V_AS | V_WR);
                retire_one(k);
            end
            I_STORE: begin
                cyc(k, V_AS);
                if (abort_store) begin
                    rst_s[k] = 1'b1;
                    mcnt[k] = 0;
                    cyc(k, '0);
                    cyc(k, '0);
                    rst_s[k] = 1'b0;
                end else begin
                    cyc(k, V_AS | V_RW);
                    retire_one(k);
                end
            end
            I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
                case (ins)
                    I_BZERO:  take = z;
                    I_BNZERO: take = !z;
                    I_BNEG:   take = n;
                    I_BNNEG:  take = !n;
                    I_BOV:    take = ov;
                    default:  take = !ov;
                endcase
                cyc(k, take ? (V_BR | V_PC) : 11'd0);
                retire_one(k);
            end
            default: begin
                cyc(k, '0);
                retire_one(k);
            end
        endcase
    endtask

    task automatic run_random(input int k, input int n);
        decoded_instruction_type ins;
        for (int i = 0; i < n; i++) begin
            ins = decoded_instruction_type'(4'($urandom_range(0, 14)));
            exec(k, ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 1'b0);
        end
    endtask

    int lit_seq [5];

    initial begin
        lit_seq = '{1, 2, 3, 0, 1};
        lit_on = 1'b0;
        lit_k = 0;
        lit_v = '0;
        lit_cnt_e = '0;
        for (int k = 0; k < 3; k++) begin
            rst_s[k] = 1'b1;
            instr_s[k] = I_NOP;
            zero_s[k] = 1'b0;
            neg_s[k] = 1'b0;
            uo_s[k] = 1'b0;
            so_s[k] = 1'b0;
            smode_s[k] = 1'b0;
            sreq_s[k] = 1'b0;
            exp_on[k] = 1'b0;
            exp_v[k] = '0;
            exp_cnt[k] = '0;
            mcnt[k] = 0;
        end
        @(posedge clk);
        #1;

        // DUT0, L=1: ADD then HALT, halt in cycle 8 with two retired
        do_reset(0);
        exec(0, I_ADD, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        exec(0, I_HALT, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        set_lit(0, V_H, 2);
        for (int i = 0; i < 4; i++) cyc(0, V_H);

        // BZERO taken then not taken
        do_reset(0);
        exec(0, I_BZERO, 1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        exec(0, I_BZERO, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);

        // Single step: 20 idle cycles, one pulse, then held again with count 1
        do_reset(0);
        smode_s[0] = 1'b1;
        exec(0, I_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 20, 1'b0);
        set_lit(0, 11'd0, 1);
        exec(0, I_MOVE, 1'b0, 1'b0, 1'b0, 1'b0, 10, 1'b0);
        smode_s[0] = 1'b0;

        // Reset during STORE_WR, then normal execution from count 0
        exec(0, I_STORE, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b1);
        set_lit(0, 11'd0, 0);
        exec(0, I_NOP, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        run_random(0, 80);
        exp_on[0] = 1'b0;

        // DUT1, L=3, signed overflow selection
        do_reset(1);
        exec(1, I_LOAD, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        exec(1, I_BOV, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0);
        exec(1, I_BNOV, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0);
        exec(1, I_BOV, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        smode_s[1] = 1'b1;
        exec(1, I_LOAD, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b0);
        smode_s[1] = 1'b0;
        run_random(1, 60);
        exec(1, I_HALT, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1, V_H);
        exp_on[1] = 1'b0;

        // DUT2, CNT_W=2: count wraps 1,2,3,0,1
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) set_lit(2, 11'd0, lit_seq[i - 1]);
            exec(2, I_NOP, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        end
        run_random(2, 60);
        exp_on[2] = 1'b0;

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
